// File: rtl/axi4lite_reg_station.sv
// AXI4-Lite register slice: one register stage on each of AW, W, B, AR and R, with error tagging and an error IRQ.
// Defining AXI4LITE_REG_STATION_ASSERT_EN compiles in internal SVA checks; behaviour is otherwise identical.
module axi4lite_reg_station #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter bit ERR_RESP_EN   = 1'b1,
    parameter bit IRQ_EN        = 1'b1,
    parameter int IRQ_HOLD_TIME = 8,
    parameter bit RST_SYNC_EN   = 1'b1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    output logic                    irq_o,

    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int STRB        = DATA_WIDTH / 8;
    localparam int ALIGN_BITS  = $clog2(STRB);
    localparam int AB          = (ALIGN_BITS > 0) ? ALIGN_BITS : 1;
    localparam int CNT_W       = $clog2(IRQ_HOLD_TIME + 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic rst_n;

    // Asynchronous assertion, synchronous release when the synchronizer is enabled.
    generate
        if (RST_SYNC_EN) begin : g_rst_sync
            logic [1:0] sync_reg;
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) sync_reg <= 2'b00;
                else          sync_reg <= {sync_reg[0], 1'b1};
            end
            assign rst_n = sync_reg[1];
        end else begin : g_rst_direct
            assign rst_n = aresetn;
        end
    endgenerate

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (ALIGN_BITS > 0) && (a[AB-1:0] != '0);
    endfunction

    logic aw_full_reg, w_full_reg, b_full_reg, ar_full_reg, r_full_reg;
    logic wr_err_reg, rd_err_reg;
    logic aw_hs, w_hs, ar_hs, sb_hs, sr_hs;

    assign s_axi_awready = !aw_full_reg;
    assign s_axi_wready  = !w_full_reg;
    assign s_axi_arready = !ar_full_reg;
    assign m_axi_bready  = !b_full_reg;
    assign m_axi_rready  = !r_full_reg;
    assign m_axi_awvalid = aw_full_reg;
    assign m_axi_wvalid  = w_full_reg;
    assign m_axi_arvalid = ar_full_reg;
    assign s_axi_bvalid  = b_full_reg;
    assign s_axi_rvalid  = r_full_reg;

    assign aw_hs = s_axi_awvalid && !aw_full_reg;
    assign w_hs  = s_axi_wvalid  && !w_full_reg;
    assign ar_hs = s_axi_arvalid && !ar_full_reg;
    assign sb_hs = b_full_reg && s_axi_bready;
    assign sr_hs = r_full_reg && s_axi_rready;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_reg  <= 1'b0;
            m_axi_awaddr <= '0;
            m_axi_awprot <= '0;
        end else if (aw_full_reg) begin
            if (m_axi_awready) aw_full_reg <= 1'b0;
        end else if (s_axi_awvalid) begin
            aw_full_reg  <= 1'b1;
            m_axi_awaddr <= s_axi_awaddr;
            m_axi_awprot <= s_axi_awprot;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            w_full_reg  <= 1'b0;
            m_axi_wdata <= '0;
            m_axi_wstrb <= '0;
        end else if (w_full_reg) begin
            if (m_axi_wready) w_full_reg <= 1'b0;
        end else if (s_axi_wvalid) begin
            w_full_reg  <= 1'b1;
            m_axi_wdata <= s_axi_wdata;
            m_axi_wstrb <= s_axi_wstrb;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            ar_full_reg  <= 1'b0;
            m_axi_araddr <= '0;
            m_axi_arprot <= '0;
        end else if (ar_full_reg) begin
            if (m_axi_arready) ar_full_reg <= 1'b0;
        end else if (s_axi_arvalid) begin
            ar_full_reg  <= 1'b1;
            m_axi_araddr <= s_axi_araddr;
            m_axi_arprot <= s_axi_arprot;
        end
    end

    // A new error set wins over the clear from the previous response.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_reg <= 1'b0;
            rd_err_reg <= 1'b0;
        end else begin
            if ((aw_hs && addr_err(s_axi_awaddr)) || (w_hs && (s_axi_wstrb == '0)))
                wr_err_reg <= 1'b1;
            else if (sb_hs)
                wr_err_reg <= 1'b0;
            if (ar_hs && addr_err(s_axi_araddr))
                rd_err_reg <= 1'b1;
            else if (sr_hs)
                rd_err_reg <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            b_full_reg  <= 1'b0;
            s_axi_bresp <= '0;
        end else if (b_full_reg) begin
            if (s_axi_bready) b_full_reg <= 1'b0;
        end else if (m_axi_bvalid) begin
            b_full_reg  <= 1'b1;
            s_axi_bresp <= (ERR_RESP_EN && wr_err_reg) ? RESP_SLVERR : m_axi_bresp;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_full_reg  <= 1'b0;
            s_axi_rdata <= '0;
            s_axi_rresp <= '0;
        end else if (r_full_reg) begin
            if (s_axi_rready) r_full_reg <= 1'b0;
        end else if (m_axi_rvalid) begin
            r_full_reg  <= 1'b1;
            s_axi_rdata <= m_axi_rdata;
            s_axi_rresp <= (ERR_RESP_EN && rd_err_reg) ? RESP_SLVERR : m_axi_rresp;
        end
    end

    generate
        if (IRQ_EN && ERR_RESP_EN) begin : g_irq
            logic             trigger;
            logic [CNT_W-1:0] irq_cnt_reg;

            // Level-sampled: a held erroneous valid keeps reloading the counter.
            assign trigger = (s_axi_awvalid && addr_err(s_axi_awaddr)) ||
                             (s_axi_arvalid && addr_err(s_axi_araddr)) ||
                             (s_axi_wvalid  && (s_axi_wstrb == '0));

            always_ff @(posedge aclk or negedge rst_n) begin
                if (!rst_n)                  irq_cnt_reg <= '0;
                else if (trigger)            irq_cnt_reg <= CNT_W'(IRQ_HOLD_TIME);
                else if (irq_cnt_reg != '0)  irq_cnt_reg <= irq_cnt_reg - 1'b1;
            end
            assign irq_o = (irq_cnt_reg != '0);

`ifdef AXI4LITE_REG_STATION_ASSERT_EN
            a_irq_hold: assert property (@(posedge aclk) disable iff (!rst_n)
                trigger |=> irq_o [*IRQ_HOLD_TIME]);
`endif
        end else begin : g_no_irq
            assign irq_o = 1'b0;
        end
    endgenerate

`ifdef AXI4LITE_REG_STATION_ASSERT_EN
    a_aw_stable: assert property (@(posedge aclk) disable iff (!rst_n)
        (m_axi_awvalid && !m_axi_awready) |=> (m_axi_awvalid && $stable(m_axi_awaddr) && $stable(m_axi_awprot)));
    a_w_stable: assert property (@(posedge aclk) disable iff (!rst_n)
        (m_axi_wvalid && !m_axi_wready) |=> (m_axi_wvalid && $stable(m_axi_wdata) && $stable(m_axi_wstrb)));
    a_ar_stable: assert property (@(posedge aclk) disable iff (!rst_n)
        (m_axi_arvalid && !m_axi_arready) |=> (m_axi_arvalid && $stable(m_axi_araddr) && $stable(m_axi_arprot)));
    a_b_stable: assert property (@(posedge aclk) disable iff (!rst_n)
        (s_axi_bvalid && !s_axi_bready) |=> (s_axi_bvalid && $stable(s_axi_bresp)));
    a_r_stable: assert property (@(posedge aclk) disable iff (!rst_n)
        (s_axi_rvalid && !s_axi_rready) |=> (s_axi_rvalid && $stable(s_axi_rdata) && $stable(s_axi_rresp)));
    a_aw_fwd: assert property (@(posedge aclk) disable iff (!rst_n)
        aw_hs |=> (m_axi_awvalid && m_axi_awaddr == $past(s_axi_awaddr) && m_axi_awprot == $past(s_axi_awprot)));
    a_w_fwd: assert property (@(posedge aclk) disable iff (!rst_n)
        w_hs |=> (m_axi_wvalid && m_axi_wdata == $past(s_axi_wdata) && m_axi_wstrb == $past(s_axi_wstrb)));
    a_ar_fwd: assert property (@(posedge aclk) disable iff (!rst_n)
        ar_hs |=> (m_axi_arvalid && m_axi_araddr == $past(s_axi_araddr) && m_axi_arprot == $past(s_axi_arprot)));
    a_r_fwd: assert property (@(posedge aclk) disable iff (!rst_n)
        (m_axi_rvalid && m_axi_rready) |=> (s_axi_rvalid && s_axi_rdata == $past(m_axi_rdata)));
`endif

endmodule

// File: tb/tb_axi4lite_reg_station.sv
// Directed bench for axi4lite_reg_station: drives both the upstream manager and the downstream subordinate.
module tb_axi4lite_reg_station;
    logic        aclk;
    logic        aresetn;
    logic        irq_o;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int passes = 0;

    axi4lite_reg_station dut (
        .aclk(aclk), .aresetn(aresetn), .irq_o(irq_o),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Every step lands 1 ns after a rising edge; inputs are driven and outputs sampled there.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
    endtask

    // One write through both sides; irq_o is sampled on steps 1..10 into irq_hist[0..9].
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] dresp,
                             output logic [31:0] o_awaddr, output logic [31:0] o_wdata, output logic [3:0] o_wstrb,
                             output logic o_fwd, output logic o_awready, output logic o_bvalid,
                             output logic [1:0] o_bresp, output logic [9:0] irq_hist);
        s_axi_awaddr = addr; s_axi_awprot = 3'b010; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        step();
        irq_hist[0] = irq_o;
        o_fwd = m_axi_awvalid && m_axi_wvalid && (m_axi_awprot == 3'b010);
        o_awaddr = m_axi_awaddr; o_wdata = m_axi_wdata; o_wstrb = m_axi_wstrb;
        o_awready = s_axi_awready;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        step();
        irq_hist[1] = irq_o;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = dresp;
        step();
        irq_hist[2] = irq_o;
        o_bvalid = s_axi_bvalid; o_bresp = s_axi_bresp;
        m_axi_bvalid = 1'b0; m_axi_bresp = '0; s_axi_bready = 1'b1;
        step();
        irq_hist[3] = irq_o;
        s_axi_bready = 1'b0;
        for (int i = 4; i < 10; i++) begin
            step();
            irq_hist[i] = irq_o;
        end
        $display("write addr=%08h strb=%h dresp=%0d -> bresp=%0d irq=%b", addr, strb, dresp, o_bresp, irq_hist);
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [1:0] dresp,
                            output logic [31:0] o_araddr, output logic o_fwd,
                            output logic o_rvalid, output logic [31:0] o_rdata, output logic [1:0] o_rresp,
                            output logic [9:0] irq_hist);
        s_axi_araddr = addr; s_axi_arprot = 3'b001; s_axi_arvalid = 1'b1;
        step();
        irq_hist[0] = irq_o;
        o_fwd = m_axi_arvalid && (m_axi_arprot == 3'b001);
        o_araddr = m_axi_araddr;
        s_axi_arvalid = 1'b0; m_axi_arready = 1'b1;
        step();
        irq_hist[1] = irq_o;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = addr ^ 32'h1234_5678; m_axi_rresp = dresp;
        step();
        irq_hist[2] = irq_o;
        o_rvalid = s_axi_rvalid; o_rdata = s_axi_rdata; o_rresp = s_axi_rresp;
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; s_axi_rready = 1'b1;
        step();
        irq_hist[3] = irq_o;
        s_axi_rready = 1'b0;
        for (int i = 4; i < 10; i++) begin
            step();
            irq_hist[i] = irq_o;
        end
        $display("read addr=%08h dresp=%0d -> rdata=%08h rresp=%0d irq=%b", addr, dresp, o_rdata, o_rresp, irq_hist);
    endtask

    task automatic test_reset();
        logic [9:0] rdy;
        idle_inputs();
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        // No clock edge has occurred yet: reset values must already be present.
        rdy = {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready,
               m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid};
        checks++;
        if (rdy !== 10'b11111_00000) $display("FAIL reset_async_handshake: got %b expected %b", rdy, 10'b11111_00000);
        else passes++;
        step(); step();
        rdy = {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready,
               m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid};
        checks++;
        if (rdy !== 10'b11111_00000) $display("FAIL reset_clocked_handshake: got %b expected %b", rdy, 10'b11111_00000);
        else passes++;
        checks++;
        if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_o);
        else passes++;
        checks++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr, s_axi_rdata} !== 128'h0)
            $display("FAIL reset_payload: got %h %h %h %h expected zeros", m_axi_awaddr, m_axi_wdata, m_axi_araddr, s_axi_rdata);
        else passes++;
        checks++;
        if ({m_axi_wstrb, m_axi_awprot, m_axi_arprot, s_axi_bresp, s_axi_rresp} !== 14'h0)
            $display("FAIL reset_small_fields: got %h %h %h %h %h expected zeros", m_axi_wstrb, m_axi_awprot, m_axi_arprot, s_axi_bresp, s_axi_rresp);
        else passes++;
        aresetn = 1'b1;
        step(); step(); step();
        $display("reset sequence done");
    endtask

    task automatic test_aligned_write();
        logic [31:0] awaddr, wdata; logic [3:0] wstrb; logic fwd, awready, bvalid; logic [1:0] bresp; logic [9:0] irqh;
        write_txn(32'h1000, 32'hA5A5_A5A5, 4'hF, 2'b00, awaddr, wdata, wstrb, fwd, awready, bvalid, bresp, irqh);
        checks++;
        if (fwd !== 1'b1) $display("FAIL wr_fwd_valid: got %b expected 1", fwd);
        else passes++;
        checks++;
        if ({awaddr, wdata, wstrb} !== {32'h1000, 32'hA5A5_A5A5, 4'hF})
            $display("FAIL wr_fwd_payload: got %h %h %h expected 00001000 a5a5a5a5 f", awaddr, wdata, wstrb);
        else passes++;
        checks++;
        if (awready !== 1'b0) $display("FAIL wr_awready_full: got %b expected 0", awready);
        else passes++;
        checks++;
        if ({bvalid, bresp} !== 3'b1_00) $display("FAIL wr_ok_bresp: got valid=%b resp=%b expected 1 00", bvalid, bresp);
        else passes++;
        checks++;
        if (irqh !== 10'b0) $display("FAIL wr_ok_irq: got %b expected 0000000000", irqh);
        else passes++;
    endtask

    task automatic test_resp_passthrough();
        logic [31:0] awaddr, wdata; logic [3:0] wstrb; logic fwd, awready, bvalid; logic [1:0] bresp; logic [9:0] irqh;
        write_txn(32'h1004, 32'h0000_00FF, 4'h1, 2'b11, awaddr, wdata, wstrb, fwd, awready, bvalid, bresp, irqh);
        checks++;
        if ({bvalid, bresp} !== 3'b1_11) $display("FAIL wr_decerr_copy: got valid=%b resp=%b expected 1 11", bvalid, bresp);
        else passes++;
    endtask

    task automatic test_aligned_read();
        logic [31:0] araddr, rdata; logic fwd, rvalid; logic [1:0] rresp; logic [9:0] irqh;
        read_txn(32'h2000, 2'b00, araddr, fwd, rvalid, rdata, rresp, irqh);
        checks++;
        if ({fwd, araddr} !== {1'b1, 32'h2000}) $display("FAIL rd_fwd: got %b %h expected 1 00002000", fwd, araddr);
        else passes++;
        // 0x2000 ^ 0x12345678
        checks++;
        if ({rvalid, rdata, rresp} !== {1'b1, 32'h1234_7678, 2'b00})
            $display("FAIL rd_ok_data: got %b %h %b expected 1 12347678 00", rvalid, rdata, rresp);
        else passes++;
        checks++;
        if (irqh !== 10'b0) $display("FAIL rd_ok_irq: got %b expected 0000000000", irqh);
        else passes++;
    endtask

    task automatic test_unaligned_read();
        logic [31:0] araddr, rdata; logic fwd, rvalid; logic [1:0] rresp; logic [9:0] irqh;
        read_txn(32'h2003, 2'b00, araddr, fwd, rvalid, rdata, rresp, irqh);
        checks++;
        if ({fwd, araddr} !== {1'b1, 32'h2003}) $display("FAIL rd_err_fwd: got %b %h expected 1 00002003", fwd, araddr);
        else passes++;
        // 0x2003 ^ 0x12345678
        checks++;
        if ({rvalid, rdata, rresp} !== {1'b1, 32'h1234_767B, 2'b10})
            $display("FAIL rd_err_resp: got %b %h %b expected 1 1234767b 10", rvalid, rdata, rresp);
        else passes++;
        // High on steps 1..8 after the trigger, low on steps 9 and 10.
        checks++;
        if (irqh !== 10'b00_1111_1111) $display("FAIL rd_err_irq: got %b expected 0011111111", irqh);
        else passes++;
    endtask

    task automatic test_write_errors();
        logic [31:0] addrs [3] = '{32'h1001, 32'h1000, 32'h1001};
        logic [3:0]  strbs [3] = '{4'hF, 4'h0, 4'h0};
        logic [31:0] awaddr, wdata; logic [3:0] wstrb; logic fwd, awready, bvalid; logic [1:0] bresp; logic [9:0] irqh;
        for (int k = 0; k < 3; k++) begin
            write_txn(addrs[k], 32'hDEAD_0000 + 32'(k), strbs[k], 2'b00, awaddr, wdata, wstrb, fwd, awready, bvalid, bresp, irqh);
            checks++;
            if ({fwd, awaddr, wstrb} !== {1'b1, addrs[k], strbs[k]})
                $display("FAIL wr_err_fwd[%0d]: got %b %h %h expected 1 %h %h", k, fwd, awaddr, wstrb, addrs[k], strbs[k]);
            else passes++;
            checks++;
            if ({bvalid, bresp} !== 3'b1_10) $display("FAIL wr_err_bresp[%0d]: got valid=%b resp=%b expected 1 10", k, bvalid, bresp);
            else passes++;
            checks++;
            if (irqh !== 10'b00_1111_1111) $display("FAIL wr_err_irq[%0d]: got %b expected 0011111111", k, irqh);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic v1, r1, v2, r2, v3;
        logic [31:0] a3;
        s_axi_awaddr = 32'h3000; s_axi_awvalid = 1'b1;
        step();
        v1 = m_axi_awvalid; r1 = s_axi_awready;
        s_axi_awaddr = 32'h3004; m_axi_awready = 1'b1;
        step();
        v2 = m_axi_awvalid; r2 = s_axi_awready;
        step();
        v3 = m_axi_awvalid; a3 = m_axi_awaddr;
        s_axi_awvalid = 1'b0;
        step();
        m_axi_awready = 1'b0;
        checks++;
        if ({v1, r1, v2, r2} !== 4'b1_0_0_1) $display("FAIL b2b_pacing: got %b%b%b%b expected 1001", v1, r1, v2, r2);
        else passes++;
        checks++;
        if ({v3, a3} !== {1'b1, 32'h3004}) $display("FAIL b2b_second: got %b %h expected 1 00003004", v3, a3);
        else passes++;
        $display("back-to-back aw 3000,3004 -> pacing=%b%b%b%b second=%h", v1, r1, v2, r2, a3);
    endtask

    task automatic test_async_reset();
        logic [31:0] awaddr, wdata; logic [3:0] wstrb; logic fwd, awready, bvalid; logic [1:0] bresp; logic [9:0] irqh;
        logic irq_before;
        logic [4:0] st;
        s_axi_awaddr = 32'h1001; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        step();
        irq_before = irq_o;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        #1 aresetn = 1'b0;
        #1;
        st = {irq_o, m_axi_awvalid, m_axi_wvalid, s_axi_awready, s_axi_wready};
        checks++;
        if ({irq_before, st} !== 6'b1_0_0_0_1_1)
            $display("FAIL async_reset_mid: got irq_before=%b state=%b expected 1 00011", irq_before, st);
        else passes++;
        idle_inputs();
        step(); step();
        aresetn = 1'b1;
        step(); step(); step();
        write_txn(32'h1000, 32'h0BAD_F00D, 4'hF, 2'b00, awaddr, wdata, wstrb, fwd, awready, bvalid, bresp, irqh);
        checks++;
        if ({fwd, bvalid, bresp} !== 4'b1_1_00) $display("FAIL post_reset_write: got fwd=%b valid=%b resp=%b expected 1 1 00", fwd, bvalid, bresp);
        else passes++;
        checks++;
        if (irqh !== 10'b0) $display("FAIL post_reset_irq: got %b expected 0000000000", irqh);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_aligned_write();
        test_resp_passthrough();
        test_aligned_read();
        test_unaligned_read();
        test_write_errors();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 ns");
        $fatal(1);
    end
endmodule
